// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer.
//   - controller state encodings (S_RUN / S_MD / S_MEMWAIT)
//   - default mult/div EX latency
//   - next-PC select codes driven by the ID stage (NPCOp)
package pipe_stall_ctrl_pkg;

  localparam logic [1:0] S_RUN     = 2'd0;
  localparam logic [1:0] S_MD      = 2'd1;
  localparam logic [1:0] S_MEMWAIT = 2'd2;

  localparam int MD_LAT_DEF = 8;

  // Any non-zero NPCOp is a taken redirect resolved in ID.
  localparam logic [1:0] NPC_SEQ    = 2'd0;
  localparam logic [1:0] NPC_BRANCH = 2'd1;
  localparam logic [1:0] NPC_JUMP   = 2'd2;
  localparam logic [1:0] NPC_JR     = 2'd3;

endpackage

// File: rtl/pipe_stall_ctrl_md_occupancy_ctr.sv
// md_occupancy_ctr: remaining-occupancy counter for a multi-cycle mult/div op.
//   clk, rst_n : clock, asynchronous active-low reset (clears the count)
//   load       : op enters EX; count becomes MD_LAT-1
//   dec        : one more EX cycle consumed; count decrements
//   (neither)  : count frozen (e.g. during a data-memory wait)
//   md_cnt     : remaining cycles after the current one
//   md_nz      : an op is still in flight (md_cnt != 0)
//   md_last    : current cycle is the last owed one (md_cnt == 1)
module md_occupancy_ctr #(
  parameter int MD_LAT = 8,
  parameter int CW     = $clog2(MD_LAT)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          dec,
  output logic [CW-1:0] md_cnt,
  output logic          md_nz,
  output logic          md_last
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      md_cnt <= '0;
    end else if (load) begin
      md_cnt <= CW'(MD_LAT - 1);
    end else if (dec) begin
      md_cnt <= md_cnt - 1'b1;
    end
  end

  assign md_nz   = (md_cnt != '0);
  assign md_last = (md_cnt == CW'(1));

endmodule

// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: central stall/flush sequencer for the 5-stage pipeline.
// Inputs : clk, rst_n (async, active low), IDEXrt/IFIDrs/IFIDrt/MemRead
//          (load-use detect), NPCOp (ID redirect), md_start (mult/div
//          issue), dmem_req/dmem_rdy (data memory wait).
// Outputs: per-register write enables / flushes (pc, IF/ID, ID/EX, EX/MEM,
//          MEM/WB), md_busy, saturating stall_cnt / flush_cnt.
// Priority each cycle: memory wait > mult/div occupancy > load-use >
// redirect > run. A register is never written and flushed in the same
// cycle outside reset; during reset every register flushes and none writes.
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int MD_LAT = MD_LAT_DEF,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       IDEXrt,
  input  logic [4:0]       IFIDrs,
  input  logic [4:0]       IFIDrt,
  input  logic             MemRead,
  input  logic [1:0]       NPCOp,
  input  logic             md_start,
  input  logic             dmem_req,
  input  logic             dmem_rdy,
  output logic             pc_wr,
  output logic             ifid_wr,
  output logic             ifid_flush,
  output logic             idex_wr,
  output logic             idex_flush,
  output logic             exmem_wr,
  output logic             exmem_flush,
  output logic             memwb_wr,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int CW = $clog2(MD_LAT);

  logic [1:0]    state, next_state;
  logic [CW-1:0] md_cnt;
  logic          md_nz, md_last, md_load, md_dec;
  logic          memw, lduse, redir, in_md;
  logic          stall_inc, flush_inc;

  assign memw  = dmem_req & ~dmem_rdy;
  assign lduse = MemRead & (IDEXrt != 5'd0) & ((IDEXrt == IFIDrs) | (IDEXrt == IFIDrt));
  assign redir = |NPCOp;

  // S_MEMWAIT resumes whatever was frozen: once the memory is ready the
  // cycle behaves like S_MD when an op is still owed, else like S_RUN.
  assign in_md = (state == S_MD) | ((state == S_MEMWAIT) & md_nz);

  md_occupancy_ctr #(.MD_LAT(MD_LAT), .CW(CW)) u_md (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (md_load),
    .dec     (md_dec),
    .md_cnt  (md_cnt),
    .md_nz   (md_nz),
    .md_last (md_last)
  );

  always_comb begin
    pc_wr       = 1'b1;
    ifid_wr     = 1'b1;
    ifid_flush  = 1'b0;
    idex_wr     = 1'b1;
    idex_flush  = 1'b0;
    exmem_wr    = 1'b1;
    exmem_flush = 1'b0;
    memwb_wr    = 1'b1;
    md_busy     = 1'b0;
    md_load     = 1'b0;
    md_dec      = 1'b0;
    stall_inc   = 1'b0;
    flush_inc   = 1'b0;
    next_state  = in_md ? S_MD : S_RUN;

    if (memw) begin
      // Full freeze; the mult/div count holds.
      pc_wr      = 1'b0;
      ifid_wr    = 1'b0;
      idex_wr    = 1'b0;
      exmem_wr   = 1'b0;
      memwb_wr   = 1'b0;
      md_busy    = in_md;
      stall_inc  = 1'b1;
      next_state = S_MEMWAIT;
    end else if (in_md | md_start) begin
      // EX occupied: front end holds, bubbles drain into MEM. md_start
      // while an op is already in flight is ignored.
      pc_wr       = 1'b0;
      ifid_wr     = 1'b0;
      idex_wr     = 1'b0;
      exmem_wr    = 1'b0;
      exmem_flush = 1'b1;
      md_busy     = 1'b1;
      stall_inc   = 1'b1;
      if (in_md) begin
        md_dec     = 1'b1;
        next_state = md_last ? S_RUN : S_MD;
      end else begin
        md_load    = 1'b1;
        next_state = S_MD;
      end
    end else if (lduse) begin
      // Redirect is deliberately dropped: the branch re-resolves next
      // cycle once the loaded operand can be forwarded.
      pc_wr      = 1'b0;
      ifid_wr    = 1'b0;
      idex_wr    = 1'b0;
      idex_flush = 1'b1;
      stall_inc  = 1'b1;
    end else if (redir) begin
      ifid_wr    = 1'b0;
      ifid_flush = 1'b1;
      flush_inc  = 1'b1;
    end

    if (!rst_n) begin
      pc_wr       = 1'b0;
      ifid_wr     = 1'b0;
      ifid_flush  = 1'b1;
      idex_wr     = 1'b0;
      idex_flush  = 1'b1;
      exmem_wr    = 1'b0;
      exmem_flush = 1'b1;
      memwb_wr    = 1'b0;
      md_busy     = 1'b0;
      stall_inc   = 1'b0;
      flush_inc   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_RUN;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state <= next_state;
      if (stall_inc && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
      if (flush_inc && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
module tb_pipe_stall_ctrl;

  localparam int MD_LAT = 8;
  localparam int CNT_W  = 32;
  localparam int SW     = 3;
  localparam int SMAX   = (1 << SW) - 1;
  localparam logic [8:0] RST_CTRL = 9'b001010100;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [4:0] IDEXrt, IFIDrs, IFIDrt;
  logic       MemRead, md_start, dmem_req, dmem_rdy;
  logic [1:0] NPCOp;

  logic pc_wr, ifid_wr, ifid_flush, idex_wr, idex_flush;
  logic exmem_wr, exmem_flush, memwb_wr, md_busy;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  logic s_pc_wr, s_ifid_wr, s_ifid_flush, s_idex_wr, s_idex_flush;
  logic s_exmem_wr, s_exmem_flush, s_memwb_wr, s_md_busy;
  logic [SW-1:0] s_stall_cnt, s_flush_cnt;

  pipe_stall_ctrl #(.MD_LAT(MD_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .IDEXrt(IDEXrt), .IFIDrs(IFIDrs), .IFIDrt(IFIDrt),
    .MemRead(MemRead), .NPCOp(NPCOp), .md_start(md_start), .dmem_req(dmem_req),
    .dmem_rdy(dmem_rdy), .pc_wr(pc_wr), .ifid_wr(ifid_wr), .ifid_flush(ifid_flush),
    .idex_wr(idex_wr), .idex_flush(idex_flush), .exmem_wr(exmem_wr),
    .exmem_flush(exmem_flush), .memwb_wr(memwb_wr), .md_busy(md_busy),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  // Narrow-counter copy: exercises saturation in a few cycles.
  pipe_stall_ctrl #(.MD_LAT(MD_LAT), .CNT_W(SW)) dut_s (
    .clk(clk), .rst_n(rst_n), .IDEXrt(IDEXrt), .IFIDrs(IFIDrs), .IFIDrt(IFIDrt),
    .MemRead(MemRead), .NPCOp(NPCOp), .md_start(md_start), .dmem_req(dmem_req),
    .dmem_rdy(dmem_rdy), .pc_wr(s_pc_wr), .ifid_wr(s_ifid_wr), .ifid_flush(s_ifid_flush),
    .idex_wr(s_idex_wr), .idex_flush(s_idex_flush), .exmem_wr(s_exmem_wr),
    .exmem_flush(s_exmem_flush), .memwb_wr(s_memwb_wr), .md_busy(s_md_busy),
    .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  // ---------------- scoreboard ----------------
  int n_assert = 0;
  int n_fail   = 0;
  logic [8:0] exp_q[$];

  // Reference model: mult/div occupancy as "EX cycles still owed", plain counts.
  int      md_owed;
  longint  m_stall, m_flush;
  int      ms_stall, ms_flush;
  int      busy_seen;
  bit      e_si, e_fi;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [8:0] ctrl_vec();
    return {pc_wr, ifid_wr, ifid_flush, idex_wr, idex_flush,
            exmem_wr, exmem_flush, memwb_wr, md_busy};
  endfunction

  task automatic model_eval(output logic [8:0] e);
    bit memw, lduse, redir;
    memw  = dmem_req && !dmem_rdy;
    lduse = MemRead && IDEXrt != 0 && (IDEXrt == IFIDrs || IDEXrt == IFIDrt);
    redir = NPCOp != 0;
    e_si = 0;
    e_fi = 0;
    if (memw) begin
      e = {8'b0, md_owed > 0};
      e_si = 1;
    end else if (md_owed > 0 || md_start) begin
      e = 9'b000000111;
      e_si = 1;
    end else if (lduse) begin
      e = 9'b000011010;
      e_si = 1;
    end else if (redir) begin
      e = 9'b101101010;
      e_fi = 1;
    end else begin
      e = 9'b110101010;
    end
  endtask

  task automatic model_step();
    bit memw;
    memw = dmem_req && !dmem_rdy;
    if (!memw) begin
      if (md_owed > 0) md_owed--;
      else if (md_start) md_owed = MD_LAT - 1;
    end
    if (e_si) begin
      m_stall++;
      if (ms_stall < SMAX) ms_stall++;
    end
    if (e_fi) begin
      m_flush++;
      if (ms_flush < SMAX) ms_flush++;
    end
  endtask

  task automatic model_reset();
    md_owed = 0;
    m_stall = 0;
    m_flush = 0;
    ms_stall = 0;
    ms_flush = 0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic mr, input logic [4:0] ert, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [1:0] npc, input logic mds,
                       input logic dreq, input logic drdy);
    MemRead  = mr;
    IDEXrt   = ert;
    IFIDrs   = rs;
    IFIDrt   = rt;
    NPCOp    = npc;
    md_start = mds;
    dmem_req = dreq;
    dmem_rdy = drdy;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Called just after a falling edge with inputs driven.
  task automatic cycle(input string tag);
    logic [8:0] e;
    #1;
    model_eval(e);
    exp_q.push_back(e);
    check({tag, "_ctrl"}, 64'(ctrl_vec()), 64'(exp_q.pop_front()));
    if (md_busy) busy_seen++;
    @(posedge clk);
    model_step();
    #1;
    check({tag, "_stall_cnt"}, 64'(stall_cnt), 64'(m_stall));
    check({tag, "_flush_cnt"}, 64'(flush_cnt), 64'(m_flush));
    check({tag, "_s_stall_cnt"}, 64'(s_stall_cnt), 64'(ms_stall));
    check({tag, "_s_flush_cnt"}, 64'(s_flush_cnt), 64'(ms_flush));
    @(negedge clk);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_ctrl"}, 64'(ctrl_vec()), 64'(RST_CTRL));
    check({tag, "_stall_cnt"}, 64'(stall_cnt), 64'd0);
    check({tag, "_flush_cnt"}, 64'(flush_cnt), 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    idle();
    model_reset();
    busy_seen = 0;
    #2;
    check_reset_state("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Load-use on rs: one stall cycle.
    drive(1, 5, 5, 0, 0, 0, 0, 0);
    cycle("lduse_rs");
    check("lduse_stall_is_1", 64'(stall_cnt), 64'd1);
    // Load-use on rt.
    drive(1, 7, 3, 7, 0, 0, 0, 0);
    cycle("lduse_rt");
    // $zero never hazards.
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    cycle("lduse_zero");
    idle();
    cycle("idle0");

    // Redirect alone, then redirect suppressed by load-use.
    drive(0, 0, 1, 2, 2'b01, 0, 0, 0);
    cycle("redir");
    drive(1, 4, 4, 1, 2'b01, 0, 0, 0);
    cycle("redir_lduse");
    drive(0, 0, 0, 0, 2'b11, 0, 0, 0);
    cycle("redir_jr");

    // Mult/div: MD_LAT busy cycles; md_start mid-op ignored.
    busy_seen = 0;
    drive(0, 0, 0, 0, 0, 1, 0, 0);
    cycle("md_issue");
    for (int i = 0; i < MD_LAT + 2; i++) begin
      drive(0, 0, 0, 0, 0, (i == 2), 0, 0);
      cycle("md_run");
    end
    check("md_busy_cycles", 64'(busy_seen), 64'(MD_LAT));

    // Mult/div with a 3-cycle memory wait inside it.
    busy_seen = 0;
    drive(0, 0, 0, 0, 0, 1, 0, 0);
    cycle("mdw_issue");
    idle();
    cycle("mdw_a");
    cycle("mdw_b");
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0, 0, 1, 0);
      cycle("mdw_wait");
    end
    drive(0, 0, 0, 0, 0, 0, 1, 1);
    cycle("mdw_rdy");
    for (int i = 0; i < MD_LAT + 2; i++) begin
      idle();
      cycle("mdw_tail");
    end
    check("mdw_busy_cycles", 64'(busy_seen), 64'(MD_LAT + 3));

    // Reset asserted in the middle of a mult/div.
    drive(0, 0, 0, 0, 0, 1, 0, 0);
    cycle("mdr_issue");
    idle();
    cycle("mdr_a");
    cycle("mdr_b");
    #2 rst_n = 1'b0;
    #1;
    check_reset_state("mid_md_reset");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    cycle("post_reset");

    // Saturation of the narrow counters.
    for (int i = 0; i < SMAX + 2; i++) begin
      drive(1, 9, 9, 0, 0, 0, 0, 0);
      cycle("sat_stall");
    end
    check("sat_stall_hold", 64'(s_stall_cnt), 64'(SMAX));
    for (int i = 0; i < SMAX + 2; i++) begin
      drive(0, 0, 0, 0, 2'b10, 0, 0, 0);
      cycle("sat_flush");
    end
    check("sat_flush_hold", 64'(s_flush_cnt), 64'(SMAX));

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
      cycle("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
